// File: rtl/pwm4sdr_pkg.sv
// Shared constants and state encoding for the PWM encoder/decoder family.
// Sample width, mid-scale offset and the two-state FSM encoding.
package pwm4sdr_pkg;

   localparam int SAMPLE_W      = 16;
   localparam int SAMPLE_OFFSET = 32768;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/pwm_duty_map.sv
// Signed sample to PWM duty map, with optional runt-pulse deadband clamp.
// Clamp present only when PWM_ENC_DEADBAND_EN is defined.
module pwm_duty_map
   import pwm4sdr_pkg::*;
#(
   parameter int PERIOD_LOG2 = 8,
   parameter int MIN_PULSE   = 4
) (
   input  logic [SAMPLE_W-1:0]  sample,
   output logic [PERIOD_LOG2:0] duty
);

   localparam int DW    = PERIOD_LOG2 + 1;
   localparam int SHIFT = SAMPLE_W - PERIOD_LOG2;

   logic [SAMPLE_W-1:0] offs;
   logic [DW-1:0]       raw;

   // offset binary: adding mid-scale maps -32768..32767 onto 0..65535
   assign offs = sample + SAMPLE_W'(SAMPLE_OFFSET);
   assign raw  = DW'(offs >> SHIFT);

`ifdef PWM_ENC_DEADBAND_EN
   localparam logic [DW-1:0] FULL   = DW'(2**PERIOD_LOG2);
   localparam logic [DW-1:0] MINP   = DW'(MIN_PULSE);
   localparam logic [DW-1:0] HI_LIM = FULL - MINP;

   // snap too-narrow high or low pulses to fully off or fully on
   always_comb begin
      duty = raw;
      if (raw < MINP)
         duty = '0;
      else if (raw > HI_LIM)
         duty = FULL;
   end
`else
   assign duty = raw;
`endif

endmodule

// File: rtl/pwm_encoder.sv
// Sample stream to fixed-period PWM encoder for the SDR TX chain.
// Optional deadband clamp enabled by defining PWM_ENC_DEADBAND_EN.
module pwm_encoder
   import pwm4sdr_pkg::*;
#(
   parameter int PERIOD_LOG2 = 8,
   parameter int AMPLITUDE   = 8192,
   parameter int MIN_PULSE   = 4
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   output logic                sample_ready,
   output logic [SAMPLE_W-1:0] pwm_out,
   output logic                pwm_level,
   output logic                period_start,
   output logic                underrun
);

   localparam int DW = PERIOD_LOG2 + 1;
   localparam logic [SAMPLE_W-1:0] AMP_POS = SAMPLE_W'(AMPLITUDE);
   localparam logic [SAMPLE_W-1:0] AMP_NEG = SAMPLE_W'(-AMPLITUDE);

   state_t                 state;
   state_t                 state_next;
   logic [PERIOD_LOG2-1:0] counter;
   logic                   pend_full;
   logic [DW-1:0]          pend_duty;
   logic [DW-1:0]          duty_active;
   logic [DW-1:0]          duty_map;
   logic                   boundary;
   logic                   xfer;
   logic                   level_next;

   pwm_duty_map #(
      .PERIOD_LOG2 (PERIOD_LOG2),
      .MIN_PULSE   (MIN_PULSE)
   ) u_map (
      .sample (sample_in),
      .duty   (duty_map)
   );

   assign boundary     = (state == RUN) && (counter == '1);
   assign sample_ready = !pend_full || boundary;
   assign xfer         = sample_valid && sample_ready;
   assign level_next   = {1'b0, counter} < duty_active;

   // FSM state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // leave IDLE on the first accepted sample; RUN is sticky
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (xfer) state_next = RUN;
         RUN:  state_next = RUN;
      endcase
   end

   // period counter, active duty and one-entry pending slot
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         counter     <= '0;
         pend_full   <= 1'b0;
         pend_duty   <= '0;
         duty_active <= '0;
      end else if (state == IDLE) begin
         counter <= '0;
         if (xfer)
            duty_active <= duty_map;
      end else begin
         counter <= counter + 1'b1;
         if (boundary) begin
            if (pend_full)
               duty_active <= pend_duty;
            pend_full <= xfer;
         end else if (xfer) begin
            pend_full <= 1'b1;
         end
         if (xfer)
            pend_duty <= duty_map;
      end
   end

   // registered output stage
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pwm_level    <= 1'b0;
         pwm_out      <= '0;
         period_start <= 1'b0;
         underrun     <= 1'b0;
      end else if (state == RUN) begin
         pwm_level    <= level_next;
         pwm_out      <= level_next ? AMP_POS : AMP_NEG;
         period_start <= (counter == '0);
         underrun     <= boundary && !pend_full;
      end else begin
         pwm_level    <= 1'b0;
         pwm_out      <= '0;
         period_start <= 1'b0;
         underrun     <= 1'b0;
      end
   end

endmodule
